// File: rtl/cla_pipe_adder.sv
// Three-stage pipelined carry-lookahead adder/subtractor with valid/ready.
// Ports: clk, rst_n; in_valid/in_ready, ain, bin, cin, sub (operand side);
// out_valid/out_ready, sum, cout, ovf, gout, pout (result side).
module cla_pipe_adder #(
    parameter int WIDTH = 32,
    parameter int GROUP = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] ain,
    input  logic [WIDTH-1:0] bin,
    input  logic             cin,
    input  logic             sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf,
    output logic             gout,
    output logic             pout
);
    localparam int NG = WIDTH / GROUP;

    if ((GROUP != 2 && GROUP != 4 && GROUP != 8) ||
        (WIDTH % GROUP) != 0 || WIDTH < 4 || WIDTH > 64) begin : g_bad_param
        $error("cla_pipe_adder: illegal WIDTH/GROUP combination");
    end

    logic v1, v2, v3;
    logic adv1, adv2, adv3;

    // An empty stage always advances, so bubbles never block upstream.
    assign adv3      = !v3 || out_ready;
    assign adv2      = !v2 || adv3;
    assign adv1      = !v1 || adv2;
    assign in_ready  = adv1;
    assign out_valid = v3;

    // Stage 1: effective operand and per-group generate/propagate.
    logic [WIDTH-1:0] b_eff, g0, p0;
    logic             c_eff;
    logic [NG-1:0]    grp_g, grp_p;

    assign b_eff = sub ? ~bin : bin;
    assign c_eff = sub | cin;
    assign g0    = ain & b_eff;
    assign p0    = ain | b_eff;

    always_comb begin : s1_lookahead
        logic t;
        grp_g = '0;
        grp_p = '1;
        t     = 1'b0;
        for (int i = 0; i < NG; i++) begin
            for (int k = 0; k < GROUP; k++) begin
                t = g0[i*GROUP+k];
                for (int j = k + 1; j < GROUP; j++)
                    t = t & p0[i*GROUP+j];
                grp_g[i] = grp_g[i] | t;
                grp_p[i] = grp_p[i] & p0[i*GROUP+k];
            end
        end
    end

    logic [WIDTH-1:0] a1, b1;
    logic             c1;
    logic [NG-1:0]    gg1, gp1;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            v1  <= 1'b0;
            a1  <= '0;
            b1  <= '0;
            c1  <= 1'b0;
            gg1 <= '0;
            gp1 <= '0;
        end else if (adv1) begin
            v1 <= in_valid;
            if (in_valid) begin
                a1  <= ain;
                b1  <= b_eff;
                c1  <= c_eff;
                gg1 <= grp_g;
                gp1 <= grp_p;
            end
        end
    end

    // Stage 2: every group carry-in as a flat sum of products.
    logic [NG-1:0] gc_n;
    logic          go_n, po_n;

    always_comb begin : s2_lookahead
        logic t;
        gc_n = '0;
        go_n = 1'b0;
        po_n = &gp1;
        t    = 1'b0;
        for (int i = 0; i < NG; i++) begin
            t = c1;
            for (int j = 0; j < i; j++)
                t = t & gp1[j];
            gc_n[i] = t;
            for (int j = 0; j < i; j++) begin
                t = gg1[j];
                for (int m = j + 1; m < i; m++)
                    t = t & gp1[m];
                gc_n[i] = gc_n[i] | t;
            end
        end
        for (int j = 0; j < NG; j++) begin
            t = gg1[j];
            for (int m = j + 1; m < NG; m++)
                t = t & gp1[m];
            go_n = go_n | t;
        end
    end

    logic [WIDTH-1:0] a2, b2;
    logic [NG-1:0]    gc2;
    logic             go2, po2;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            v2  <= 1'b0;
            a2  <= '0;
            b2  <= '0;
            gc2 <= '0;
            go2 <= 1'b0;
            po2 <= 1'b0;
        end else if (adv2) begin
            v2 <= v1;
            if (v1) begin
                a2  <= a1;
                b2  <= b1;
                gc2 <= gc_n;
                go2 <= go_n;
                po2 <= po_n;
            end
        end
    end

    // Stage 3: in-group carries from each group's carry-in.
    logic [WIDTH-1:0] g2, p2, carry;
    logic             cw;

    assign g2 = a2 & b2;
    assign p2 = a2 | b2;

    always_comb begin : s3_carries
        logic t, tt;
        int   base;
        carry = '0;
        cw    = 1'b0;
        t     = 1'b0;
        tt    = 1'b0;
        base  = 0;
        for (int i = 0; i < NG; i++) begin
            base = i * GROUP;
            for (int k = 0; k <= GROUP; k++) begin
                t = gc2[i];
                for (int j = 0; j < k; j++)
                    t = t & p2[base+j];
                for (int j = 0; j < k; j++) begin
                    tt = g2[base+j];
                    for (int m = j + 1; m < k; m++)
                        tt = tt & p2[base+m];
                    t = t | tt;
                end
                if (k < GROUP)
                    carry[base+k] = t;
                else if (i == NG - 1)
                    cw = t;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            v3   <= 1'b0;
            sum  <= '0;
            cout <= 1'b0;
            ovf  <= 1'b0;
            gout <= 1'b0;
            pout <= 1'b0;
        end else if (adv3) begin
            v3 <= v2;
            if (v2) begin
                sum  <= a2 ^ b2 ^ carry;
                cout <= cw;
                ovf  <= carry[WIDTH-1] ^ cw;
                gout <= go2;
                pout <= po2;
            end
        end
    end

endmodule

// File: tb/tb_cla_pipe_adder.sv
// Self-checking bench for cla_pipe_adder: directed table, scoreboard
// streaming/backpressure/reset on 16/4, plus 8/2 exhaustive and 64/8 random.
module tb_cla_pipe_adder;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    int npass = 0;
    int ntot  = 0;

    task automatic chk(input string nm, input logic [67:0] act,
                       input logic [67:0] exp);
        ntot++;
        if (act === exp) npass++;
        else $display("FAIL %s: got %0h want %0h", nm, act, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Independent reference: plain wide addition, result {sum,cout,ovf,gout,pout}.
    function automatic logic [67:0] ref_model(input int w,
        input logic [63:0] a, input logic [63:0] b,
        input logic ci, input logic sb);
        logic [63:0] mask, bb, s;
        logic [64:0] t, u;
        logic co, ov, go, po;
        mask = (w == 64) ? '1 : ((64'd1 << w) - 64'd1);
        a  = a & mask;
        bb = (sb ? ~b : b) & mask;
        t  = {1'b0, a} + {1'b0, bb} + {64'd0, (sb | ci)};
        u  = {1'b0, a} + {1'b0, bb};
        s  = t[63:0] & mask;
        co = t[w];
        ov = (a[w-1] == bb[w-1]) && (t[w-1] != a[w-1]);
        go = u[w];
        po = (((a | bb) & mask) == mask);
        return {s, co, ov, go, po};
    endfunction

    // ---------------- main DUT: WIDTH=16, GROUP=4 ----------------
    logic rst_n, in_valid, cin, sub, out_ready;
    logic [15:0] ain, bin, sum;
    logic in_ready, out_valid, cout, ovf, gout, pout;

    cla_pipe_adder #(.WIDTH(16), .GROUP(4)) dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready),
        .ain(ain), .bin(bin), .cin(cin), .sub(sub),
        .out_valid(out_valid), .out_ready(out_ready),
        .sum(sum), .cout(cout), .ovf(ovf), .gout(gout), .pout(pout)
    );

    logic [67:0] q[$];
    int nin = 0;
    int nout = 0;

    always @(negedge clk) begin
        if (!rst_n) begin
            q.delete();
        end else begin
            if (out_valid) begin
                if (q.size() == 0) chk("spurious_out16", 68'd1, 68'd0);
                else begin
                    chk("sb16", {48'd0, sum, cout, ovf, gout, pout}, q[0]);
                    if (out_ready) begin
                        void'(q.pop_front());
                        nout++;
                    end
                end
            end
            if (in_valid && in_ready) begin
                q.push_back(ref_model(16, {48'd0, ain}, {48'd0, bin}, cin, sub));
                nin++;
            end
        end
    end

    // ---------------- sweep DUTs ----------------
    logic rst2_n;
    logic iv8, ci8, sb8, ir8, ov8, co8, of8, go8, po8;
    logic [7:0] a8, b8, s8;
    logic iv64, ci64, sb64, or64, ir64, ov64, co64, of64, go64, po64;
    logic [63:0] a64, b64, s64;
    logic done8 = 1'b0;
    logic done64 = 1'b0;

    cla_pipe_adder #(.WIDTH(8), .GROUP(2)) dut8 (
        .clk(clk), .rst_n(rst2_n),
        .in_valid(iv8), .in_ready(ir8),
        .ain(a8), .bin(b8), .cin(ci8), .sub(sb8),
        .out_valid(ov8), .out_ready(1'b1),
        .sum(s8), .cout(co8), .ovf(of8), .gout(go8), .pout(po8)
    );

    cla_pipe_adder #(.WIDTH(64), .GROUP(8)) dut64 (
        .clk(clk), .rst_n(rst2_n),
        .in_valid(iv64), .in_ready(ir64),
        .ain(a64), .bin(b64), .cin(ci64), .sub(sb64),
        .out_valid(ov64), .out_ready(or64),
        .sum(s64), .cout(co64), .ovf(of64), .gout(go64), .pout(po64)
    );

    logic [67:0] q8[$];
    logic [67:0] q64[$];
    int nin64 = 0;

    always @(negedge clk) begin
        if (!rst2_n) begin
            q8.delete();
            q64.delete();
        end else begin
            if (ov8) begin
                if (q8.size() == 0) chk("spurious_out8", 68'd1, 68'd0);
                else chk("sb8", {56'd0, s8, co8, of8, go8, po8}, q8.pop_front());
            end
            if (iv8 && ir8)
                q8.push_back(ref_model(8, {56'd0, a8}, {56'd0, b8}, ci8, sb8));
            if (ov64) begin
                if (q64.size() == 0) chk("spurious_out64", 68'd1, 68'd0);
                else begin
                    chk("sb64", {s64, co64, of64, go64, po64}, q64[0]);
                    if (or64) void'(q64.pop_front());
                end
            end
            if (iv64 && ir64) begin
                q64.push_back(ref_model(64, a64, b64, ci64, sb64));
                nin64++;
            end
        end
    end

    initial begin
        rst2_n = 1'b0;
        iv8 = 1'b0; a8 = '0; b8 = '0; ci8 = 1'b0; sb8 = 1'b0;
        iv64 = 1'b0; a64 = '0; b64 = '0; ci64 = 1'b0; sb64 = 1'b0;
        or64 = 1'b1;
        repeat (2) tick();
        rst2_n = 1'b1;
        fork
            begin
                for (int a = 0; a < 256; a++) begin
                    for (int b = 0; b < 256; b++) begin
                        a8 = 8'(a);
                        b8 = 8'(b);
                        {ci8, sb8} = 2'($urandom_range(0, 3));
                        iv8 = 1'b1;
                        tick();
                    end
                end
                iv8 = 1'b0;
                repeat (6) tick();
                chk("drain8", 68'(q8.size()), 68'd0);
                done8 = 1'b1;
            end
            begin
                for (int c = 0; c < 20000 && nin64 < 3000; c++) begin
                    a64 = {$urandom, $urandom};
                    b64 = {$urandom, $urandom};
                    ci64 = 1'($urandom);
                    sb64 = 1'($urandom);
                    iv64 = 1'($urandom);
                    or64 = 1'($urandom);
                    tick();
                end
                chk("count64", 68'(nin64), 68'd3000);
                iv64 = 1'b0;
                or64 = 1'b1;
                repeat (6) tick();
                chk("drain64", 68'(q64.size()), 68'd0);
                done64 = 1'b1;
            end
        join
    end

    // ---------------- directed vectors ----------------
    typedef struct {
        logic [15:0] a, b;
        logic        ci, sb;
        logic [15:0] s;
        logic        co, ov, go, po;
    } vec_t;

    vec_t tv[7];
    int lat, k;

    initial begin
        tv[0] = '{16'hFFFF, 16'h0001, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0, 1'b1, 1'b1};
        tv[1] = '{16'hFFFF, 16'h0000, 1'b1, 1'b0, 16'h0000, 1'b1, 1'b0, 1'b0, 1'b1};
        tv[2] = '{16'h8000, 16'h0001, 1'b0, 1'b1, 16'h7FFF, 1'b1, 1'b1, 1'b1, 1'b0};
        tv[3] = '{16'h0003, 16'h0005, 1'b1, 1'b1, 16'hFFFE, 1'b0, 1'b0, 1'b0, 1'b0};
        tv[4] = '{16'h7FFF, 16'h0001, 1'b0, 1'b0, 16'h8000, 1'b0, 1'b1, 1'b0, 1'b0};
        tv[5] = '{16'h1234, 16'h4321, 1'b1, 1'b0, 16'h5556, 1'b0, 1'b0, 1'b0, 1'b0};
        tv[6] = '{16'h0000, 16'h0000, 1'b0, 1'b1, 16'h0000, 1'b1, 1'b0, 1'b0, 1'b1};

        rst_n = 1'b0;
        in_valid = 1'b0;
        out_ready = 1'b1;
        ain = '0; bin = '0; cin = 1'b0; sub = 1'b0;
        #1;
        chk("rst_out_valid", 68'(out_valid), 68'd0);
        chk("rst_in_ready", 68'(in_ready), 68'd1);
        repeat (3) tick();
        chk("rst_outs", 68'({sum, cout, ovf, gout, pout}), 68'd0);
        chk("rst_in_ready_held", 68'(in_ready), 68'd1);
        rst_n = 1'b1;
        repeat (5) tick();
        chk("idle_out_valid", 68'(out_valid), 68'd0);
        chk("idle_in_ready", 68'(in_ready), 68'd1);

        for (int i = 0; i < 7; i++) begin
            ain = tv[i].a; bin = tv[i].b; cin = tv[i].ci; sub = tv[i].sb;
            in_valid = 1'b1;
            tick();
            in_valid = 1'b0;
            ain = 16'($urandom);
            bin = 16'($urandom);
            lat = 1;
            while (!out_valid && lat < 10) begin
                tick();
                lat++;
            end
            chk($sformatf("lat_%0d", i), 68'(lat), 68'd3);
            chk($sformatf("vec_%0d", i),
                68'({sum, cout, ovf, gout, pout}),
                68'({tv[i].s, tv[i].co, tv[i].ov, tv[i].go, tv[i].po}));
            tick();
        end

        // streaming, one result per cycle after the fill
        for (int i = 0; i < 100; i++) begin
            ain = 16'($urandom); bin = 16'($urandom);
            cin = 1'($urandom); sub = 1'($urandom);
            in_valid = 1'b1;
            chk("stream_in_ready", 68'(in_ready), 68'd1);
            if (i >= 3) chk("stream_out_valid", 68'(out_valid), 68'd1);
            tick();
        end
        in_valid = 1'b0;
        repeat (5) tick();
        chk("stream_drain", 68'(q.size()), 68'd0);
        chk("stream_count", 68'(nout), 68'(nin));

        // fill the pipe while stalled
        out_ready = 1'b0;
        in_valid = 1'b1;
        k = 0;
        while (in_ready && k < 10) begin
            ain = 16'($urandom); bin = 16'($urandom);
            cin = 1'($urandom); sub = 1'($urandom);
            tick();
            k++;
        end
        chk("full_count", 68'(k), 68'd3);
        chk("full_in_ready", 68'(in_ready), 68'd0);
        repeat (3) begin
            ain = 16'($urandom); bin = 16'($urandom);
            tick();
        end
        chk("full_in_ready_hold", 68'(in_ready), 68'd0);
        out_ready = 1'b1;
        #1;
        chk("in_ready_follows", 68'(in_ready), 68'd1);
        tick();
        in_valid = 1'b0;
        repeat (6) tick();
        chk("full_drain", 68'(q.size()), 68'd0);
        chk("full_count_io", 68'(nout), 68'(nin));

        // random backpressure
        for (int i = 0; i < 400; i++) begin
            ain = 16'($urandom); bin = 16'($urandom);
            cin = 1'($urandom); sub = 1'($urandom);
            in_valid = 1'($urandom);
            out_ready = 1'($urandom);
            tick();
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        repeat (6) tick();
        chk("bp_drain", 68'(q.size()), 68'd0);
        chk("bp_count_io", 68'(nout), 68'(nin));

        // reset while beats are in flight
        in_valid = 1'b1;
        repeat (4) begin
            ain = 16'($urandom); bin = 16'($urandom);
            tick();
        end
        chk("pre_rst_valid", 68'(out_valid), 68'd1);
        rst_n = 1'b0;
        #1;
        chk("midrst_out_valid", 68'(out_valid), 68'd0);
        chk("midrst_outs", 68'({sum, cout, ovf, gout, pout}), 68'd0);
        chk("midrst_in_ready", 68'(in_ready), 68'd1);
        in_valid = 1'b0;
        tick();
        rst_n = 1'b1;
        repeat (6) tick();
        chk("post_rst_idle", 68'(out_valid), 68'd0);

        for (int c = 0; c < 80000 && !(done8 && done64); c++) tick();
        chk("sweep_done", 68'(done8 && done64), 68'd1);

        $display("%0d/%0d checks passed", npass, ntot);
        $finish;
    end
endmodule
